mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waiting for ram_ack before abort.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port if_req, input, 1: fetch stage requests instruction read.
REQ-005 SHALL have port if_addr, input, 32: fetch address.
REQ-006 SHALL have port if_rdata, output, 32: fetched instruction, valid while if_ready=1.
REQ-007 SHALL have port if_ready, output, 1: one-cycle fetch completion pulse.
REQ-008 SHALL have ports mem_rd and mem_wr, input, 1 each: MEM stage read or write request.
REQ-009 SHALL have ports mem_addr and mem_wdata, input, 32 each: data address and write data.
REQ-010 SHALL have port mem_rdata, output, 32: load data, valid while mem_ready=1.
REQ-011 SHALL have port mem_ready, output, 1: one-cycle data completion pulse.
REQ-012 SHALL have ports if_stall and mem_stall, output, 1 each: hold-off to PC/pipeline write enables.
REQ-013 SHALL have ports ram_req, ram_we, output, 1 each; ram_addr, ram_wdata, output, 32 each: shared single-port RAM request.
REQ-014 SHALL have ports ram_rdata, input, 32, and ram_ack, input, 1: RAM response, ack sampled at clock edge.
REQ-015 SHALL have port err, output, 1: sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-017 In IDLE, SHALL grant MEM if (mem_rd|mem_wr), else IF if if_req, else stay IDLE.
REQ-018 Exception to REQ-017: if previous grant was MEM and if_req=1, SHALL grant IF (no fetch starvation).
REQ-019 On grant, SHALL register address, wdata and we into ram_* outputs and assert ram_req from the next cycle (BUSY state).
REQ-020 ram_we SHALL be 1 only for MEM grant with mem_wr=1; mem_rd and mem_wr both high SHALL be served as a write.
REQ-021 ram_req and all ram_* outputs SHALL remain stable in BUSY until ram_ack=1 is sampled.
REQ-022 On ram_ack in BUSY, SHALL capture ram_rdata into served port's rdata, drop ram_req, move to DONE.
REQ-023 In DONE (exactly one cycle), SHALL assert ready of served port only, then go to IDLE; no grant in DONE.
REQ-024 rdata outputs SHALL hold last captured value outside ready cycle; writes SHALL capture nothing.
REQ-025 Minimum latency: request sampled in cycle N, ram_ack in N+1 -> ready in N+2.
REQ-026 if_stall SHALL equal if_req & ~if_ready; mem_stall SHALL equal (mem_rd|mem_wr) & ~mem_ready (combinational).
REQ-027 Requesters SHALL hold request and operands until their ready pulse; arbiter does not re-check them in BUSY.
REQ-028 Wait counter SHALL clear on grant and increment each BUSY cycle without ack.
REQ-029 If counter reaches TIMEOUT in BUSY with no ack, SHALL drop ram_req, set err=1, load rdata=0, go to DONE (ready still pulses).
REQ-030 ram_ack outside BUSY SHALL be ignored.
REQ-031 err SHALL remain 1 until reset.

Reset
REQ-032 With reset=0 at a clock edge: state=IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0, err=0, counter=0, last-grant=IF.
REQ-033 Reset asserted mid-BUSY SHALL abort: ram_req=0 after that edge, no ready pulse issued.

Verification
REQ-034 if_req=1, if_addr=0x00400004, ram_ack one cycle after ram_req with rdata=0x8C080000 -> if_ready pulses 2 cycles after request, if_rdata=0x8C080000, if_stall low in that cycle.
REQ-035 if_req and mem_rd same cycle, mem_addr=0x10 -> MEM served first, then IF next; if_stall high throughout MEM service.
REQ-036 mem_wr=1, mem_addr=0x20, mem_wdata=0x12345678 -> ram_we=1, ram_addr=0x20, ram_wdata=0x12345678 held until ack; mem_rdata unchanged.
REQ-037 Back-to-back mem_rd with if_req held -> grants alternate MEM, IF, MEM; neither port starves.
REQ-038 TIMEOUT=4, ram_ack never asserted -> ram_req drops after 4 BUSY cycles, err=1, mem_ready pulses with mem_rdata=0; err stays 1 until reset.
REQ-039 reset=0 during IF_BUSY -> next cycle ram_req=0, state IDLE, no if_ready pulse; late ram_ack ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port RAM between the instruction fetch (IF) stage and the
// memory (MEM) stage of a pipeline. Data accesses normally win. A fetch that
// is waiting when the previous grant went to MEM is served next, so the fetch
// stage cannot be starved by a stream of loads and stores.
//
// One transaction runs at a time:
//   IDLE  -> grant and register the RAM request
//   BUSY  -> hold ram_* stable until ram_ack, or abort after TIMEOUT cycles
//   DONE  -> one-cycle ready pulse to the served port, then back to IDLE
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   if_req, if_addr            fetch request and address
//   if_rdata, if_ready         fetched word and one-cycle completion pulse
//   mem_rd, mem_wr             data read / write request (both high = write)
//   mem_addr, mem_wdata        data address and store data
//   mem_rdata, mem_ready       load data and one-cycle completion pulse
//   if_stall, mem_stall        combinational hold-off for each requester
//   ram_req, ram_we            RAM request strobe and write enable
//   ram_addr, ram_wdata        RAM address and write data
//   ram_rdata, ram_ack         RAM read data and completion acknowledge
//   err                        sticky flag, set when a RAM access times out
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    MEM_BUSY,
    DONE
  } state_t;

  // Wide enough to hold the value TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   cnt_inc;
  logic            last_mem;    // previous grant went to the MEM stage
  logic            mem_any;
  logic            grant_if;
  logic            grant_mem;
  logic            timeout_hit;

  assign mem_any = mem_rd | mem_wr;

  // A pending fetch after a MEM grant takes priority; otherwise MEM first.
  assign grant_if  = if_req & (last_mem | ~mem_any);
  assign grant_mem = mem_any & ~(last_mem & if_req);

  assign cnt_inc     = wait_cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_any & ~mem_ready;

  // NOTE: every register here, including the captured read data, is cleared
  // by reset; there is no storage array whose reset would be expensive, so
  // nothing is left holding X after reset.
  // NOTE: state uses non-blocking assignments only, so every branch below
  // reads the pre-edge values (e.g. ram_we while deciding whether to capture).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      last_mem  <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses raised on entry to DONE.
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_mem) begin
            state     <= MEM_BUSY;
            ram_req   <= 1'b1;
            ram_we    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            wait_cnt  <= '0;
            last_mem  <= 1'b1;
          end else if (grant_if) begin
            state     <= IF_BUSY;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            wait_cnt  <= '0;
            last_mem  <= 1'b0;
          end
        end

        IF_BUSY, MEM_BUSY: begin
          if (ram_ack || timeout_hit) begin
            // Completion or abort: an aborted read returns zero.
            state   <= DONE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            if (state == IF_BUSY) begin
              if_ready <= 1'b1;
              if_rdata <= ram_ack ? ram_rdata : '0;
            end else begin
              mem_ready <= 1'b1;
              if (!ram_we) begin
                mem_rdata <= ram_ack ? ram_rdata : '0;
              end
            end
            if (!ram_ack) begin
              err <= 1'b1;
            end
          end
          if (!ram_ack) begin
            wait_cnt <= cnt_inc;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
